// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: four-requester round-robin arbiter that owns the select of a
// shared 4:1 data line.
//
// Ports
//   clk       in   1  single clock, all state on rising edge
//   rst       in   1  synchronous, active-high reset
//   REQ       in   4  requests, bit0=A .. bit3=D
//   D         in   4  shared-line data, bit n belongs to requester n
//   GNT       out  4  registered one-hot grant
//   S         out  2  registered mux select, equal to the granted index
//   V         out  1  high exactly when GNT is non-zero
//   Y         out  1  D[S] while V=1, else 0 (combinational)
//
// Parameters
//   HOLD_MAX  maximum consecutive owner cycles before a forced rotation (2..255);
//             only meaningful when MUX4_ARB_TIMEOUT_EN is defined.
//
// Build options
//   MUX4_ARB_TIMEOUT_EN  when defined, adds a hold counter that rotates the grant
//                        after HOLD_MAX owner cycles if another requester waits.
//                        When undefined, the owner keeps the grant until it drops
//                        its request.
//
// Behaviour summary
//   - IDLE: any request is arbitrated on the edge; the grant appears one cycle later.
//   - BUSY: the grant is held while the owner keeps requesting. When the owner drops,
//     the next requester is granted on the same edge (no idle bubble); with nobody
//     else waiting the arbiter returns to IDLE, keeping S.
//   - Arbitration scans PTR, PTR+1, PTR+2, PTR+3 (mod 4). PTR becomes grant+1 on each
//     new grant, so the previous owner is always scanned last.

module mux4_rr_arbiter #(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] REQ,
  input  logic [3:0] D,
  output logic [3:0] GNT,
  output logic [1:0] S,
  output logic       V,
  output logic       Y
);

  // Reject out-of-range hold limits at elaboration time.
  if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("mux4_rr_arbiter: HOLD_MAX must be in 2..255");
  end

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } state_e;

  state_e     state_q;
  logic [3:0] gnt_q;
  logic [1:0] sel_q;
  logic [1:0] ptr_q;

  logic [1:0] owner;
  logic [3:0] others;
  logic       held;
  logic       expired;
  logic       do_grant;
  logic       go_idle;
  logic [1:0] grant_idx;

`ifdef MUX4_ARB_TIMEOUT_EN
  localparam logic [8:0] HoldMaxW = 9'(HOLD_MAX);
  localparam logic [7:0] HoldMaxC = 8'(HOLD_MAX);

  // Owner cycles already completed in the current tenure.
  logic [7:0] cnt_q;
  logic [8:0] cnt_inc;
`endif

  // First set bit of req, scanning start, start+1, start+2, start+3 (mod 4).
  // The loop runs from the far end so the nearest hit is the last assignment.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] start);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = start;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (req[idx]) begin
        pick = idx;
      end
    end
    return pick;
  endfunction

  always_comb begin
    owner  = sel_q;
    // The current owner is removed from re-arbitration so it always ranks last.
    others = REQ & ~(4'b0001 << owner);
    held   = REQ[owner];

    expired = 1'b0;
`ifdef MUX4_ARB_TIMEOUT_EN
    // The edge being evaluated completes one more owner cycle.
    cnt_inc = {1'b0, cnt_q} + 9'd1;
    expired = (cnt_inc >= HoldMaxW);
`endif

    do_grant  = 1'b0;
    go_idle   = 1'b0;
    grant_idx = rr_pick(REQ, ptr_q);

    unique case (state_q)
      StIdle: begin
        do_grant = |REQ;
      end
      StBusy: begin
        // Leave the current grant on release, or on timeout with someone waiting.
        if (!held || (expired && (|others))) begin
          if (|others) begin
            do_grant  = 1'b1;
            grant_idx = rr_pick(others, ptr_q);
          end else begin
            go_idle = 1'b1;
          end
        end
      end
      default: begin
        go_idle = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'b00;
      ptr_q   <= 2'b00;
`ifdef MUX4_ARB_TIMEOUT_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      if (do_grant) begin
        state_q <= StBusy;
        gnt_q   <= 4'b0001 << grant_idx;
        sel_q   <= grant_idx;
        ptr_q   <= grant_idx + 2'd1;
      end else if (go_idle) begin
        // S is deliberately kept; only a new grant moves the select.
        state_q <= StIdle;
        gnt_q   <= 4'b0000;
      end

`ifdef MUX4_ARB_TIMEOUT_EN
      if (do_grant || go_idle) begin
        cnt_q <= 8'd0;
      end else if (state_q == StBusy) begin
        // Saturates at HOLD_MAX while nobody else is waiting.
        cnt_q <= expired ? HoldMaxC : cnt_inc[7:0];
      end
`endif
    end
  end

  assign GNT = gnt_q;
  assign S   = sel_q;
  assign V   = |gnt_q;
  assign Y   = V & D[sel_q];

  // Structural invariants of the grant outputs.
  a_gnt_onehot0 : assert property (@(posedge clk) $onehot0(GNT));
  a_gnt_matches_sel : assert property (@(posedge clk) (GNT != 4'b0000) |-> (GNT == (4'b0001 << S)));

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Self-checking bench for mux4_rr_arbiter: a directed vector table covering the
// documented scenarios, hand sequences for the hold-timeout build option, and a
// randomized phase compared against a behavioural model of the arbitration rules.

module tb_mux4_rr_arbiter;

  localparam int unsigned HOLD = 8;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] d;
  logic [3:0] gnt;
  logic [1:0] s;
  logic       v;
  logic       y;

  int n_checks;
  int n_fail;

  // Behavioural model: owner index or -1 when idle, last select, rotate pointer,
  // and completed owner cycles.
  int m_owner;
  int m_sel;
  int m_ptr;
  int m_cnt;

  mux4_rr_arbiter #(
    .HOLD_MAX(HOLD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .REQ(req),
    .D  (d),
    .GNT(gnt),
    .S  (s),
    .V  (v),
    .Y  (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] d;
    logic [3:0] gnt;
    logic [1:0] s;
    logic       v;
    logic       y;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic model_edge(input logic r, input logic [3:0] rq);
    logic [3:0] cand;
    bit         timed_out;
    bit         found;
    int         start;
    if (r) begin
      m_owner = -1;
      m_sel   = 0;
      m_ptr   = 0;
      m_cnt   = 0;
      return;
    end
    if (m_owner < 0) begin
      cand  = rq;
      start = m_ptr;
    end else begin
      timed_out = 1'b0;
`ifdef MUX4_ARB_TIMEOUT_EN
      timed_out = (m_cnt + 1 >= HOLD);
`endif
      cand = rq;
      cand[m_owner] = 1'b0;
      if (rq[m_owner] && !(timed_out && cand != 4'b0000)) begin
        m_cnt = (m_cnt + 1 > HOLD) ? HOLD : m_cnt + 1;
        return;
      end
      if (cand == 4'b0000) begin
        m_owner = -1;
        m_cnt   = 0;
        return;
      end
      start = m_ptr;
    end
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (start + k) % 4;
      if (!found && cand[c]) begin
        found   = 1'b1;
        m_owner = c;
        m_sel   = c;
        m_ptr   = (c + 1) % 4;
        m_cnt   = 0;
      end
    end
  endtask

  // Drive inputs for one cycle, update the model, and land #1 after the edge.
  task automatic apply(input logic r, input logic [3:0] rq, input logic [3:0] dd);
    rst = r;
    req = rq;
    d   = dd;
    model_edge(r, rq);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    logic [3:0] e_gnt;
    logic       e_v;
    logic       e_y;
    e_gnt = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    e_v   = (m_owner >= 0);
    e_y   = e_v ? d[m_sel] : 1'b0;
    check({tag, " GNT"}, 32'(gnt), 32'(e_gnt));
    check({tag, " S"},   32'(s),   32'(m_sel));
    check({tag, " V"},   32'(v),   32'(e_v));
    check({tag, " Y"},   32'(y),   32'(e_y));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_owner  = -1;
    m_sel    = 0;
    m_ptr    = 0;
    m_cnt    = 0;
    rst      = 1'b1;
    req      = 4'b0000;
    d        = 4'b0000;

    //               rst   req      d        gnt      s      v     y
    vecs[0]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0}; // reset
    vecs[1]  = '{1'b0, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0}; // A first after reset
    vecs[2]  = '{1'b0, 4'b1110, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1}; // A drops -> B, Y=D[1]
    vecs[3]  = '{1'b0, 4'b1110, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0}; // B holds, Y follows D
    vecs[4]  = '{1'b0, 4'b1100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0}; // B drops -> C
    vecs[5]  = '{1'b0, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b0}; // C drops -> D
    vecs[6]  = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0}; // D drops -> A (wrap)
    vecs[7]  = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0}; // A drops -> C
    vecs[8]  = '{1'b0, 4'b0101, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0}; // A ignored while C holds
    vecs[9]  = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0}; // C drops, A wins
    vecs[10] = '{1'b0, 4'b0101, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0}; // C back, still A
    vecs[11] = '{1'b0, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0}; // A releases -> C
    vecs[12] = '{1'b1, 4'b0100, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0}; // reset mid-grant
    vecs[13] = '{1'b0, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0}; // A after reset
    vecs[14] = '{1'b0, 4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0}; // idle, Y=0 with D=1111
    vecs[15] = '{1'b0, 4'b1000, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b1}; // D pulse 1
    vecs[16] = '{1'b0, 4'b1000, 4'b1111, 4'b1000, 2'd3, 1'b1, 1'b1}; // D pulse 2
    vecs[17] = '{1'b0, 4'b1000, 4'b0111, 4'b1000, 2'd3, 1'b1, 1'b0}; // D pulse 3, D[3]=0
    vecs[18] = '{1'b0, 4'b0000, 4'b1111, 4'b0000, 2'd3, 1'b0, 1'b0}; // idle, S retained
    vecs[19] = '{1'b0, 4'b0000, 4'b1111, 4'b0000, 2'd3, 1'b0, 1'b0}; // still idle

    for (int i = 0; i < 20; i++) begin
      string tag;
      apply(vecs[i].rst, vecs[i].req, vecs[i].d);
      tag = $sformatf("vec%0d", i);
      check({tag, " GNT"}, 32'(gnt), 32'(vecs[i].gnt));
      check({tag, " S"},   32'(s),   32'(vecs[i].s));
      check({tag, " V"},   32'(v),   32'(vecs[i].v));
      check({tag, " Y"},   32'(y),   32'(vecs[i].y));
    end

`ifdef MUX4_ARB_TIMEOUT_EN
    // A and B both held: ownership alternates every HOLD cycles.
    apply(1'b1, 4'b0000, 4'b0000);
    for (int i = 0; i < 4 * HOLD; i++) begin
      logic [3:0] e;
      apply(1'b0, 4'b0011, 4'b0000);
      e = (((i / HOLD) % 2) == 0) ? 4'b0001 : 4'b0010;
      check($sformatf("timeout_ab cyc%0d GNT", i), 32'(gnt), 32'(e));
    end
    // Only A held: no rotation past HOLD cycles.
    apply(1'b1, 4'b0000, 4'b0000);
    for (int i = 0; i < 3 * HOLD; i++) begin
      apply(1'b0, 4'b0001, 4'b0000);
      check($sformatf("timeout_a cyc%0d GNT", i), 32'(gnt), 32'(4'b0001));
    end
    // Counter saturated with A alone; a waiting B now takes over on the next edge.
    apply(1'b0, 4'b0011, 4'b0000);
    check("timeout_sat_then_b GNT", 32'(gnt), 32'(4'b0010));
`endif

    // Randomized phase against the model.
    apply(1'b1, 4'b0000, 4'b0000);
    check_model("rand_reset");
    for (int i = 0; i < 600; i++) begin
      logic       r;
      logic [3:0] rq;
      r  = ($urandom_range(0, 59) == 0);
      rq = req;
      if ($urandom_range(0, 3) == 0) begin
        rq = 4'($urandom);
      end
      apply(r, rq, 4'($urandom));
      check_model($sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
